ieee_754_divider: RTL and testbench

- Iterative IEEE 754 single-precision divider (result = rs1 / rs2); the inverse operation of the team's iterative FP multiplier.
- Same start/busy/valid handshake as the multiplier, so the FPU dispatch logic can drive both blocks identically.
- Radix-2 restoring mantissa division, one quotient bit per cycle.
- Round-to-nearest-even; subnormals are flushed to zero.

---
 rtl/fp32_pkg.sv | 18 +
 rtl/ieee_754_divider_if.sv | 17 +
 rtl/fp_div_mant_core.sv | 60 ++++++
 rtl/ieee_754_divider.sv | 161 ++++++++++++++++
 tb/tb_ieee_754_divider.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared single-precision constants and the sequencer state type used by the
// iterative FP divider (and its multiplier sibling).
package fp32_pkg;

   localparam int          BIAS    = 127;
   localparam int          EXP_MAX = 255;
   localparam int          QBITS   = 26;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PREP  = 2'd1,
      DIV   = 2'd2,
      ROUND = 2'd3
   } state_t;

endpackage

// File: rtl/ieee_754_divider_if.sv
// Operand/result handshake bundle shared by the FPU dispatch and the divider.
interface ieee_754_divider_if;

   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        start;
   logic [31:0] result;
   logic        valid;
   logic        busy;

   modport master (output rs1, output rs2, output start,
                   input  result, input valid, input busy);

   modport slave  (input  rs1, input rs2, input start,
                   output result, output valid, output busy);

endinterface

// File: rtl/fp_div_mant_core.sv
// Radix-2 restoring significand divider: one quotient bit per clock, QBITS bits.
module fp_div_mant_core
   import fp32_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [QBITS-1:0] a_i,
   input  logic [QBITS-1:0] b_i,
   input  logic             go_i,
   output logic [QBITS-1:0] q_o,
   output logic             sticky_o,
   output logic             done_o
);

   localparam logic [4:0] LAST = 5'(QBITS - 1);

   logic [QBITS-1:0] rem_q;
   logic [QBITS-1:0] div_q;
   logic [QBITS-1:0] quo_q;
   logic [4:0]       cnt_q;
   logic             run_q;

   logic             ge_d;
   logic [QBITS-1:0] diff_d;

   always_comb begin
      ge_d   = (rem_q >= div_q);
      diff_d = ge_d ? (rem_q - div_q) : rem_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         div_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (go_i) begin
         rem_q <= a_i;
         div_q <= b_i;
         quo_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         // diff < divisor < 2^24, so the bit shifted out is always zero
         rem_q <= {diff_d[QBITS-2:0], 1'b0};
         quo_q <= {quo_q[QBITS-2:0], ge_d};
         if (cnt_q == LAST) begin
            run_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 5'd1;
         end
      end
   end

   assign q_o      = quo_q;
   assign sticky_o = |rem_q;
   assign done_o   = run_q && (cnt_q == LAST);

endmodule

// File: rtl/ieee_754_divider.sv
// Iterative IEEE 754 single-precision divider (rs1 / rs2), RNE rounding,
// subnormal inputs and results flushed to zero.
//
// state | meaning
// IDLE  | waiting for start; result held
// PREP  | classify operands, emit specials, prenormalize significands
// DIV   | restoring significand loop running in the core
// ROUND | apply RNE, range-check exponent, publish result
module ieee_754_divider
   import fp32_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   ieee_754_divider_if.slave   dbus
);

   localparam logic signed [9:0] BIAS_S    = 10'(BIAS);
   localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

   state_t             state_q;
   logic [31:0]        op_a_q;
   logic [31:0]        op_b_q;
   logic [31:0]        result_q;
   logic               valid_q;
   logic               busy_q;
   logic               sign_q;
   logic signed [9:0]  exp_q;

   logic [7:0]         e1, e2;
   logic [22:0]        m1, m2;
   logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic               sign_d;
   logic               special_d;
   logic [31:0]        special_res_d;
   logic [23:0]        sig_a, sig_b;
   logic               a_lt_b;
   logic [QBITS-1:0]   core_a, core_b;
   logic signed [9:0]  exp_d;
   logic               core_go;

   logic [QBITS-1:0]   quo;
   logic               sticky;
   logic               core_done;
   logic               inc_d;
   logic [31:0]        rounded_d;
   logic [31:0]        round_res_d;

   always_comb begin
      e1     = op_a_q[30:23];
      e2     = op_b_q[30:23];
      m1     = op_a_q[22:0];
      m2     = op_b_q[22:0];
      a_zero = (e1 == 8'h00);
      b_zero = (e2 == 8'h00);
      a_inf  = (e1 == 8'hFF) && (m1 == 23'd0);
      b_inf  = (e2 == 8'hFF) && (m2 == 23'd0);
      a_nan  = (e1 == 8'hFF) && (m1 != 23'd0);
      b_nan  = (e2 == 8'hFF) && (m2 != 23'd0);
      sign_d = op_a_q[31] ^ op_b_q[31];

      special_d     = 1'b1;
      special_res_d = 32'd0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         special_res_d = QNAN;
      end else if (b_zero || a_inf) begin
         special_res_d = {sign_d, POS_INF[30:0]};
      end else if (a_zero || b_inf) begin
         special_res_d = {sign_d, 31'd0};
      end else begin
         special_d = 1'b0;
      end

      // Doubling A when A < B keeps the quotient in [1,2), so q[25] is the hidden bit
      sig_a  = {1'b1, m1};
      sig_b  = {1'b1, m2};
      a_lt_b = (sig_a < sig_b);
      core_a = a_lt_b ? {1'b0, sig_a, 1'b0} : {2'b00, sig_a};
      core_b = {2'b00, sig_b};
      exp_d  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS_S
               - (a_lt_b ? 10'sd1 : 10'sd0);
      core_go = (state_q == PREP) && !special_d;
   end

   fp_div_mant_core u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_i      (core_a),
      .b_i      (core_b),
      .go_i     (core_go),
      .q_o      (quo),
      .sticky_o (sticky),
      .done_o   (core_done)
   );

   always_comb begin
      inc_d     = quo[1] & (quo[0] | sticky | quo[2]);
      // A mantissa carry ripples into the exponent field; 254 + 1 lands on inf
      rounded_d = {sign_q, exp_q[7:0], quo[QBITS-2:2]} + 32'(inc_d);
      if (exp_q >= EXP_MAX_S) begin
         round_res_d = {sign_q, POS_INF[30:0]};
      end else if (exp_q <= 10'sd0) begin
         round_res_d = {sign_q, 31'd0};
      end else begin
         round_res_d = rounded_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (dbus.start && !busy_q) begin
                  op_a_q  <= dbus.rs1;
                  op_b_q  <= dbus.rs2;
                  busy_q  <= 1'b1;
                  state_q <= PREP;
               end
            end
            PREP: begin
               sign_q <= sign_d;
               if (special_d) begin
                  result_q <= special_res_d;
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  exp_q   <= exp_d;
                  state_q <= DIV;
               end
            end
            DIV: begin
               if (core_done) begin
                  state_q <= ROUND;
               end
            end
            ROUND: begin
               result_q <= round_res_d;
               valid_q  <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dbus.result = result_q;
   assign dbus.valid  = valid_q;
   assign dbus.busy   = busy_q;

endmodule

// File: tb/tb_ieee_754_divider.sv
// Scoreboard bench for ieee_754_divider: expected quotients are queued at accept
// and popped when valid pulses.
module tb_ieee_754_divider;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ieee_754_divider_if dif ();

   ieee_754_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dbus  (dif)
   );

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] sb_q[$];

   // Caller sits #1 after a rising edge; returns #1 after the accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      dif.rs1   = a;
      dif.rs2   = b;
      dif.start = 1'b1;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
   endtask

   // Cycles from the last sampled edge until valid is seen, or -1 on timeout.
   task automatic wait_valid(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (dif.valid === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic pop_exp(output logic [31:0] e);
      e = 32'hDEAD_BEEF;
      if (sb_q.size() > 0) e = sb_q.pop_front();
   endtask

   task automatic test_reset();
      dif.rs1 = '0; dif.rs2 = '0; dif.start = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (dif.result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want %h", dif.result, 32'd0); end
      n_vec++; if (dif.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dif.valid); end
      n_vec++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", dif.busy); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_table(input string tag, input logic [31:0] va[], input logic [31:0] vb[],
                            input logic [31:0] vr[], input int lat);
      int          cyc;
      logic [31:0] e;
      for (int i = 0; i < va.size(); i++) begin
         issue(va[i], vb[i]);
         sb_q.push_back(vr[i]);
         n_vec++; if (dif.busy !== 1'b1) begin n_bad++; $display("FAIL %s[%0d]_busy_after_accept got %b want 1", tag, i, dif.busy); end
         wait_valid(cyc);
         pop_exp(e);
         n_vec++; if (cyc !== lat) begin n_bad++; $display("FAIL %s[%0d]_latency got %0d want %0d", tag, i, cyc, lat); end
         n_vec++; if (dif.result !== e) begin n_bad++; $display("FAIL %s[%0d]_result %h/%h got %h want %h", tag, i, va[i], vb[i], dif.result, e); end
         n_vec++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL %s[%0d]_busy_at_valid got %b want 0", tag, i, dif.busy); end
         @(posedge clk);
         #1;
         n_vec++; if (dif.valid !== 1'b0) begin n_bad++; $display("FAIL %s[%0d]_valid_pulse got %b want 0", tag, i, dif.valid); end
         n_vec++; if (dif.result !== e) begin n_bad++; $display("FAIL %s[%0d]_result_hold got %h want %h", tag, i, dif.result, e); end
      end
   endtask

   task automatic test_normal();
      logic [31:0] va[] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h40000000,
                            32'h41100000, 32'h40E00000, 32'h3F800000};
      logic [31:0] vb[] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40400000,
                            32'h40400000, 32'h40E00000, 32'h00800000};
      logic [31:0] vr[] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h3F2AAAAB,
                            32'h40400000, 32'h3F800000, 32'h7E800000};
      run_table("normal", va, vb, vr, 28);
   endtask

   task automatic test_special();
      logic [31:0] va[] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000, 32'h00000000,
                            32'h7FC00001, 32'h3F800000, 32'hFF800000, 32'h40000000};
      logic [31:0] vb[] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h40000000,
                            32'h3F800000, 32'hFF800000, 32'h40000000, 32'h00000001};
      logic [31:0] vr[] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                            32'h7FC00000, 32'h80000000, 32'hFF800000, 32'h7F800000};
      run_table("special", va, vb, vr, 1);
   endtask

   task automatic test_range();
      logic [31:0] va[] = '{32'h7F000000, 32'h00800000};
      logic [31:0] vb[] = '{32'h00800000, 32'h7F000000};
      logic [31:0] vr[] = '{32'h7F800000, 32'h00000000};
      run_table("range", va, vb, vr, 28);
   endtask

   task automatic test_busy_ignore();
      int          cyc;
      int          extra;
      logic [31:0] e;
      issue(32'h40C00000, 32'h40000000);
      sb_q.push_back(32'h40400000);
      repeat (9) @(posedge clk);
      #1;
      issue(32'h3F800000, 32'h40400000);
      n_vec++; if (dif.busy !== 1'b1) begin n_bad++; $display("FAIL ignore_busy got %b want 1", dif.busy); end
      wait_valid(cyc);
      pop_exp(e);
      n_vec++; if (cyc + 10 !== 28) begin n_bad++; $display("FAIL ignore_latency got %0d want 28", cyc + 10); end
      n_vec++; if (dif.result !== e) begin n_bad++; $display("FAIL ignore_result got %h want %h", dif.result, e); end
      extra = 0;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk);
         #1;
         if (dif.valid === 1'b1 || dif.busy === 1'b1) extra++;
      end
      n_vec++; if (extra !== 0) begin n_bad++; $display("FAIL ignore_no_second_op got %0d active cycles want 0", extra); end
      n_vec++; if (dif.result !== e) begin n_bad++; $display("FAIL ignore_result_hold got %h want %h", dif.result, e); end
   endtask

   task automatic test_back_to_back();
      int          cyc;
      logic [31:0] e;
      issue(32'h40C00000, 32'h40000000);
      sb_q.push_back(32'h40400000);
      wait_valid(cyc);
      pop_exp(e);
      n_vec++; if (cyc !== 28) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 28", cyc); end
      n_vec++; if (dif.result !== e) begin n_bad++; $display("FAIL b2b_first_result got %h want %h", dif.result, e); end
      issue(32'h3F800000, 32'h40400000);
      sb_q.push_back(32'h3EAAAAAB);
      n_vec++; if (dif.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy got %b want 1", dif.busy); end
      n_vec++; if (dif.valid !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_valid got %b want 0", dif.valid); end
      n_vec++; if (dif.result !== 32'h40400000) begin n_bad++; $display("FAIL b2b_result_held got %h want %h", dif.result, 32'h40400000); end
      wait_valid(cyc);
      pop_exp(e);
      n_vec++; if (cyc !== 28) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 28", cyc); end
      n_vec++; if (dif.result !== e) begin n_bad++; $display("FAIL b2b_second_result got %h want %h", dif.result, e); end
   endtask

   task automatic test_reset_abort();
      int          cyc;
      int          extra;
      logic [31:0] e;
      issue(32'h40C00000, 32'h40000000);
      sb_q.push_back(32'h40400000);
      repeat (14) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      n_vec++; if (dif.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", dif.busy); end
      n_vec++; if (dif.valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %b want 0", dif.valid); end
      n_vec++; if (dif.result !== 32'd0) begin n_bad++; $display("FAIL abort_result got %h want %h", dif.result, 32'd0); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (dif.valid === 1'b1) extra++;
      end
      n_vec++; if (extra !== 0) begin n_bad++; $display("FAIL abort_no_valid got %0d pulses want 0", extra); end
      issue(32'h40C00000, 32'h40000000);
      sb_q.push_back(32'h40400000);
      wait_valid(cyc);
      pop_exp(e);
      n_vec++; if (cyc !== 28) begin n_bad++; $display("FAIL abort_rerun_latency got %0d want 28", cyc); end
      n_vec++; if (dif.result !== e) begin n_bad++; $display("FAIL abort_rerun_result got %h want %h", dif.result, e); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_special();
      test_range();
      test_busy_ignore();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
